// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefDepth   = 64;
  localparam int unsigned DefTimeout = 8;
  // Wide enough for the largest legal timeout (255).
  localparam int unsigned CntWidth   = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that
// was not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_sel_o,
  output logic       gnt_any_o
);

  always_comb begin
    gnt_any_o = |req_i;
    gnt_sel_o = (req_i == 2'b11) ? ~last_gnt_i : req_i[1];
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one valid/ready single-port memory between two masters, one access at a
// time, with a per-access timeout that completes the access with an error flag.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s0_valid_i,
  input  logic [ADDR_WIDTH-1:0] s0_addr_i,
  input  logic [WIDTH-1:0]      s0_wdata_i,
  input  logic                  s0_wr_rd_en_i,
  output logic                  s0_ready_o,
  output logic [WIDTH-1:0]      s0_rdata_o,
  output logic                  s0_err_o,
  input  logic                  s1_valid_i,
  input  logic [ADDR_WIDTH-1:0] s1_addr_i,
  input  logic [WIDTH-1:0]      s1_wdata_i,
  input  logic                  s1_wr_rd_en_i,
  output logic                  s1_ready_o,
  output logic [WIDTH-1:0]      s1_rdata_o,
  output logic                  s1_err_o,
  output logic                  m_valid_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  output logic                  m_wr_rd_en_o,
  input  logic                  m_ready_i,
  input  logic [WIDTH-1:0]      m_rdata_i
);

  arb_state_e            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
  logic                  m_wr_q, m_wr_d;
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            err_q, err_d;
  logic [WIDTH-1:0]      rdata_q [2];
  logic [WIDTH-1:0]      rdata_d [2];

  logic gnt_sel, gnt_any;

  rr_arb2 u_rr_arb2 (
    .req_i      ({s1_valid_i, s0_valid_i}),
    .last_gnt_i (last_gnt_q),
    .gnt_sel_o  (gnt_sel),
    .gnt_any_o  (gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wr_d     = m_wr_q;
    ready_d    = ready_q;
    err_d      = err_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          gnt_d     = gnt_sel;
          m_valid_d = 1'b1;
          m_addr_d  = gnt_sel ? s1_addr_i     : s0_addr_i;
          m_wdata_d = gnt_sel ? s1_wdata_i    : s0_wdata_i;
          m_wr_d    = gnt_sel ? s1_wr_rd_en_i : s0_wr_rd_en_i;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        m_valid_d = 1'b0;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A memory response in the timeout cycle still wins over the abort.
        if (m_ready_i) begin
          if (!m_wr_q) rdata_d[gnt_q] = m_rdata_i;
          ready_d[gnt_q] = 1'b1;
          err_d[gnt_q]   = 1'b0;
          state_d        = StResp;
        end else if (cnt_q == CntWidth'(TIMEOUT - 1)) begin
          ready_d[gnt_q] = 1'b1;
          err_d[gnt_q]   = 1'b1;
          state_d        = StResp;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StResp: begin
        ready_d    = '0;
        err_d      = '0;
        last_gnt_d = gnt_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wr_q     <= 1'b0;
      ready_q    <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wr_q     <= m_wr_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign s0_ready_o   = ready_q[0];
  assign s1_ready_o   = ready_q[1];
  assign s0_err_o     = err_q[0];
  assign s1_err_o     = err_q[1];
  assign s0_rdata_o   = rdata_q[0];
  assign s1_rdata_o   = rdata_q[1];
  assign m_valid_o    = m_valid_q;
  assign m_addr_o     = m_addr_q;
  assign m_wdata_o    = m_wdata_q;
  assign m_wr_rd_en_o = m_wr_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: two request drivers, a memory with programmable
// response delay, and a transaction-level model predicting every grant and response.
module tb_mem_arbiter_2p;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned T  = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic          wr;
    int            gap;
  } req_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid [2];
  logic [AW-1:0] s_addr  [2];
  logic [W-1:0]  s_wdata [2];
  logic          s_wr    [2];
  logic          s0_ready_o, s1_ready_o, s0_err_o, s1_err_o;
  logic [W-1:0]  s0_rdata_o, s1_rdata_o;
  logic          m_valid_o, m_wr_rd_en_o;
  logic [AW-1:0] m_addr_o;
  logic [W-1:0]  m_wdata_o;
  logic          m_ready;
  logic [W-1:0]  m_rdata;
  logic [1:0]    rdy_w;

  assign rdy_w = {s1_ready_o, s0_ready_o};

  always #5 clk = ~clk;

  mem_arbiter_2p #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (T)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s0_valid_i    (s_valid[0]),
    .s0_addr_i     (s_addr[0]),
    .s0_wdata_i    (s_wdata[0]),
    .s0_wr_rd_en_i (s_wr[0]),
    .s0_ready_o    (s0_ready_o),
    .s0_rdata_o    (s0_rdata_o),
    .s0_err_o      (s0_err_o),
    .s1_valid_i    (s_valid[1]),
    .s1_addr_i     (s_addr[1]),
    .s1_wdata_i    (s_wdata[1]),
    .s1_wr_rd_en_i (s_wr[1]),
    .s1_ready_o    (s1_ready_o),
    .s1_rdata_o    (s1_rdata_o),
    .s1_err_o      (s1_err_o),
    .m_valid_o     (m_valid_o),
    .m_addr_o      (m_addr_o),
    .m_wdata_o     (m_wdata_o),
    .m_wr_rd_en_o  (m_wr_rd_en_o),
    .m_ready_i     (m_ready),
    .m_rdata_i     (m_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] init_word(input int i);
    return (i == 5) ? 16'hBEEF : (16'(i) * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Memory: responds cur_delay cycles after sampling valid (1 = next cycle).
  int            dly_mode = 0;
  int            cur_delay = 1;
  logic [W-1:0]  mem [D];
  bit            mem_init_done = 1'b0;
  logic          mem_busy;
  int            mem_left;
  logic [AW-1:0] mem_a;

  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (!mem_init_done) begin
      for (int i = 0; i < int'(D); i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
      mem_busy      <= 1'b0;
      mem_left      <= 0;
      m_rdata       <= '0;
    end else if (m_valid_o) begin
      if (m_wr_rd_en_o) mem[m_addr_o] <= m_wdata_o;
      mem_a <= m_addr_o;
      if (cur_delay <= 1) begin
        m_ready  <= 1'b1;
        m_rdata  <= mem[m_addr_o];
        mem_busy <= 1'b0;
      end else begin
        mem_busy <= 1'b1;
        mem_left <= cur_delay - 1;
      end
    end else if (mem_busy) begin
      if (mem_left == 1) begin
        m_ready  <= 1'b1;
        m_rdata  <= mem[mem_a];
        mem_busy <= 1'b0;
      end else begin
        mem_left <= mem_left - 1;
      end
    end
  end

  // Requests as presented at each edge, i.e. what an idle arbiter would see.
  logic [1:0]    snap_vld;
  logic [AW-1:0] snap_addr  [2];
  logic [W-1:0]  snap_wdata [2];
  logic          snap_wr    [2];

  always @(posedge clk) begin
    snap_vld <= {s_valid[1], s_valid[0]};
    for (int i = 0; i < 2; i++) begin
      snap_addr[i]  <= s_addr[i];
      snap_wdata[i] <= s_wdata[i];
      snap_wr[i]    <= s_wr[i];
    end
  end

  // Reference model state.
  logic [W-1:0] shadow [D];
  logic [W-1:0] prdata [2];
  int           last_gnt = 1;
  bit           outstanding = 1'b0;
  int           exp_p, exp_lat, t0;
  logic [W-1:0] exp_rdata;
  logic         exp_err;
  int           cyc = 0;
  int           resp_cnt [2] = '{0, 0};
  int           err_cnt = 0;
  int           gnt_log [$];
  bit           prev_mv = 1'b0;
  bit           prev_rdy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (m_valid_o) begin
          check("mvalid_pulse", 32'(prev_mv), 0);
          check("mvalid_while_busy", 32'(outstanding), 0);
          check("grant_has_req", 32'(snap_vld != 2'b00), 1);
          exp_p = (snap_vld == 2'b11) ? 1 - last_gnt : (snap_vld[1] ? 1 : 0);
          check("m_addr", 32'(m_addr_o), 32'(snap_addr[exp_p]));
          check("m_wr", 32'(m_wr_rd_en_o), 32'(snap_wr[exp_p]));
          if (snap_wr[exp_p]) check("m_wdata", 32'(m_wdata_o), 32'(snap_wdata[exp_p]));
          cur_delay = (dly_mode == 0) ? 1 :
                      (dly_mode == 1) ? int'($urandom_range(1, T + 2)) : 1000;
          if (snap_wr[exp_p]) shadow[snap_addr[exp_p]] = snap_wdata[exp_p];
          exp_err   = cur_delay > int'(T);
          exp_lat   = exp_err ? int'(T) + 1 : cur_delay + 1;
          exp_rdata = (!snap_wr[exp_p] && !exp_err) ? shadow[snap_addr[exp_p]] : prdata[exp_p];
          outstanding = 1'b1;
          t0 = cyc;
        end
        if (rdy_w != 2'b00) begin
          check("ready_pulse", 32'(prev_rdy), 0);
          check("ready_onehot", 32'(rdy_w != 2'b11), 1);
          check("ready_expected", 32'(outstanding), 1);
          if (outstanding) begin
            check("resp_port", rdy_w[1] ? 1 : 0, 32'(exp_p));
            check("resp_rdata", 32'(rdy_w[1] ? s1_rdata_o : s0_rdata_o), 32'(exp_rdata));
            check("resp_err", 32'(rdy_w[1] ? s1_err_o : s0_err_o), 32'(exp_err));
            check("resp_latency", 32'(cyc - t0), 32'(exp_lat));
            prdata[exp_p] = exp_rdata;
            last_gnt = exp_p;
            gnt_log.push_back(exp_p);
            resp_cnt[exp_p]++;
            if (exp_err) err_cnt++;
            outstanding = 1'b0;
          end
        end else begin
          check("err_without_ready", 32'({s1_err_o, s0_err_o}), 0);
        end
        prev_mv  = m_valid_o;
        prev_rdy = (rdy_w != 2'b00);
      end
    end
  end

  // Request drivers: hold each request until its ready, then take the next.
  req_t pq [2][$];
  int   drv_busy [2] = '{0, 0};

  task automatic drive(input int p);
    req_t r;
    forever begin
      @(negedge clk);
      if (s_valid[p] && rdy_w[p]) s_valid[p] = 1'b0;
      if (!s_valid[p] && pq[p].size() > 0) begin
        r = pq[p].pop_front();
        drv_busy[p] = 1;
        repeat (r.gap) @(negedge clk);
        s_addr[p]   = r.addr;
        s_wdata[p]  = r.wdata;
        s_wr[p]     = r.wr;
        s_valid[p]  = 1'b1;
        drv_busy[p] = 0;
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  task automatic push(input int p, input int a, input int wd, input bit wr, input int gap);
    req_t r;
    r.addr  = AW'(a);
    r.wdata = W'(wd);
    r.wr    = wr;
    r.gap   = gap;
    pq[p].push_back(r);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && !(pq[0].size() == 0 && pq[1].size() == 0 && drv_busy[0] == 0 &&
                           drv_busy[1] == 0 && !s_valid[0] && !s_valid[1] && !outstanding)) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < budget), 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pq[0].delete();
    pq[1].delete();
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    rst = 1'b1;
    outstanding = 1'b0;
    last_gnt = 1;
    prdata[0] = '0;
    prdata[1] = '0;
    @(negedge clk);
    check("rst_rdata", {s1_rdata_o, s0_rdata_o}, 0);
    check("rst_flags", 32'({s1_ready_o, s0_ready_o, s1_err_o, s0_err_o}), 0);
    check("rst_mem_port", 32'({m_valid_o, m_wr_rd_en_o, m_addr_o, m_wdata_o}), 0);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < int'(D); i++) shadow[i] = init_word(i);
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_addr[i]  = '0;
      s_wdata[i] = '0;
      s_wr[i]    = 1'b0;
    end
    rst = 1'b1;
    do_reset();

    repeat (20) begin
      @(negedge clk);
      check("idle_mvalid", 32'(m_valid_o), 0);
      check("idle_ready", 32'(rdy_w), 0);
    end

    push(0, 5, 0, 1'b0, 0);
    wait_drain(100);
    check("read_beef", 32'(s0_rdata_o), 32'hBEEF);
    check("s1_quiet", 32'({s1_ready_o, s1_err_o, s1_rdata_o}), 0);

    base = resp_cnt[1];
    push(1, 63, 16'h1234, 1'b1, 0);
    push(1, 63, 0, 1'b0, 0);
    wait_drain(100);
    check("s1_resp_count", 32'(resp_cnt[1] - base), 2);
    check("s1_rdata_1234", 32'(s1_rdata_o), 32'h1234);

    dly_mode = 2;
    base = err_cnt;
    push(0, 7, 0, 1'b0, 0);
    wait_drain(100);
    check("timeout_err_count", 32'(err_cnt - base), 1);
    check("timeout_rdata_kept", 32'(s0_rdata_o), 32'hBEEF);
    dly_mode = 0;
    push(0, 63, 0, 1'b0, 0);
    wait_drain(100);
    check("after_timeout_read", 32'(s0_rdata_o), 32'h1234);

    dly_mode = 2;
    push(0, 9, 0, 1'b0, 0);
    n = 0;
    while (!outstanding && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 32'(outstanding), 1);
    repeat (3) @(negedge clk);
    do_reset();
    dly_mode = 0;
    push(1, 5, 0, 1'b0, 0);
    wait_drain(100);
    check("post_reset_s1", 32'(s1_rdata_o), 32'hBEEF);

    do_reset();
    gnt_log.delete();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      push(0, i, 0, 1'b0, 0);
      push(1, 10 + i, 0, 1'b0, 0);
    end
    wait_drain(200);
    check("contention_count", 32'(gnt_log.size()), 6);
    for (int i = 0; i < gnt_log.size(); i++) check("contention_order", 32'(gnt_log[i]), 32'(i % 2));

    dly_mode = 1;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        push(p, int'($urandom_range(0, D - 1)), int'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
    end
    wait_drain(5000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
